// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle.
// Decoder and register-file side in, EX-stage side out.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic              id_wbs, id_mm, id_wre, id_wm, id_am;
    logic              id_ni, id_wme, id_alu_mux, id_alu_mux1, id_rde;
    logic [2:0]        id_aluop;
    logic [1:0]        id_ri;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_uses_rs1, id_uses_rs2;

    logic              ex_valid;
    logic [3:0]        ex_opcode;
    logic              ex_wbs, ex_mm, ex_wre, ex_wm, ex_am;
    logic              ex_ni, ex_wme, ex_alu_mux, ex_alu_mux1, ex_rde;
    logic [2:0]        ex_aluop;
    logic [1:0]        ex_ri;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;

    modport slave (
        input  id_valid, id_opcode, id_wbs, id_mm, id_wre, id_wm,
               id_am, id_ni, id_wme, id_alu_mux, id_alu_mux1, id_rde,
               id_aluop, id_ri, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_opcode, ex_wbs, ex_mm, ex_wre, ex_wm,
               ex_am, ex_ni, ex_wme, ex_alu_mux, ex_alu_mux1, ex_rde,
               ex_aluop, ex_ri, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd
    );

    modport master (
        output id_valid, id_opcode, id_wbs, id_mm, id_wre, id_wm,
               id_am, id_ni, id_wme, id_alu_mux, id_alu_mux1, id_rde,
               id_aluop, id_ri, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_opcode, ex_wbs, ex_mm, ex_wre, ex_wm,
               ex_am, ex_ni, ex_wme, ex_alu_mux, ex_alu_mux1, ex_rde,
               ex_aluop, ex_ri, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard FSM,
// branch flush, downstream hold and a bubble counter.
module id_ex_stage #(
    parameter int         DATA_W            = 32,
    parameter int         REG_AW            = 4,
    parameter int         LOAD_STALL_CYCLES = 1,
    parameter logic [3:0] LDR_OPCODE        = 4'b1001
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus,
    input  logic         flush_i,
    input  logic         ex_hold_i,
    output logic         stall_o,
    output logic [15:0]  bubble_count
);
    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic              wbs, mm, wre, wm, am;
        logic              ni, wme, alu_mux, alu_mux1, rde;
        logic [2:0]        aluop;
        logic [1:0]        ri;
        logic [DATA_W-1:0] rd1, rd2, imm;
        logic [REG_AW-1:0] rs1, rs2, rd;
    } bundle_t;

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

    bundle_t    id_b, ex_q, ex_d;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       haz, load_bubble, count_bubble;
    logic       rs1_hit, rs2_hit;

    assign id_b = {bus.id_valid, bus.id_opcode, bus.id_wbs, bus.id_mm,
                   bus.id_wre, bus.id_wm, bus.id_am, bus.id_ni,
                   bus.id_wme, bus.id_alu_mux, bus.id_alu_mux1,
                   bus.id_rde, bus.id_aluop, bus.id_ri, bus.id_rd1,
                   bus.id_rd2, bus.id_imm, bus.id_rs1, bus.id_rs2,
                   bus.id_rd};

    assign {bus.ex_valid, bus.ex_opcode, bus.ex_wbs, bus.ex_mm,
            bus.ex_wre, bus.ex_wm, bus.ex_am, bus.ex_ni,
            bus.ex_wme, bus.ex_alu_mux, bus.ex_alu_mux1,
            bus.ex_rde, bus.ex_aluop, bus.ex_ri, bus.ex_rd1,
            bus.ex_rd2, bus.ex_imm, bus.ex_rs1, bus.ex_rs2,
            bus.ex_rd} = ex_q;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        rs1_hit = bus.id_uses_rs1 && (bus.id_rs1 == ex_q.rd);
        rs2_hit = bus.id_uses_rs2 && (bus.id_rs2 == ex_q.rd);
        haz     = bus.id_valid && ex_q.valid && ex_q.wre &&
                  (ex_q.opcode == LDR_OPCODE) && (rs1_hit || rs2_hit);
    end

    // State and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flush > hold > stall countdown > new hazard.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        priority case (1'b1)
            flush_i: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            ex_hold_i: begin
            end
            state_q == STALL: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RUN;
            end
            haz: begin
                cnt_d   = CNT_INIT;
                state_d = (CNT_INIT != 3'd0) ? STALL : RUN;
            end
            default: begin
            end
        endcase
    end

    // Outputs: bubble insertion, upstream stall, bubble accounting.
    always_comb begin
        load_bubble  = 1'b0;
        count_bubble = 1'b0;
        stall_o      = 1'b0;
        priority case (1'b1)
            flush_i: begin
                load_bubble  = 1'b1;
                count_bubble = 1'b1;
            end
            ex_hold_i: stall_o = 1'b1;
            state_q == STALL, haz: begin
                load_bubble  = 1'b1;
                count_bubble = 1'b1;
                stall_o      = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) stall_o = 1'b0;
    end

    // Next EX bundle; empty decode slots become clean bubbles.
    always_comb begin
        ex_d = ex_q;
        if (load_bubble) ex_d = '0;
        else if (!ex_hold_i) ex_d = id_b.valid ? id_b : '0;
    end

    // EX bundle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_count <= '0;
        else if (count_bubble && bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the pipelined CPU. Sits directly downstream of the opcode decoder and register file.
- Captures the decoded control bundle, the operands and the register addresses on each clock, and presents them to the EX stage.
- Contains the load-use hazard FSM, which inserts bubbles and stalls fetch/decode. Also handles branch flush and a downstream hold.
- Keeps a saturating count of inserted bubbles for debug.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 4, register address width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..7)
LDR_OPCODE, 4'b1001, opcode treated as a load

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
id_opcode  in  4  decoded instruction opcode
id_wbs, id_mm, id_wre, id_wm, id_am, id_ni, id_wme, id_alu_mux, id_alu_mux1, id_rde  in  1 each  decoder control outputs
id_aluop  in  3  decoder ALU operation
id_ri  in  2  decoder register/immediate select
id_rd1, id_rd2, id_imm  in  DATA_W each  register-file reads and extended immediate
id_rs1, id_rs2, id_rd  in  REG_AW each  source and destination register addresses
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads that source
flush_i  in  1  branch resolved taken; squash decode
ex_hold_i  in  1  EX/MEM cannot accept; freeze this stage
ex_valid, ex_opcode, ex_<each control>, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd  out  same widths as id_*  registered bundle
stall_o  out  1  hold PC and IF/ID register this cycle (combinational)
bubble_count  out  16  saturating count of bubbles inserted

Behaviour:
- Reset (async assert, sync release): all ex_* = 0, ex_valid = 0, FSM = RUN, stall counter = 0, bubble_count = 0. stall_o = 0 while reset is asserted.
- Bubble definition: ex_valid = 0, all control bits and fields = 0. This guarantees ex_wre = 0, ex_wme = 0 and ex_ni = 0. Operand and address fields are also 0.
- X sanitising: when id_valid = 0, a bubble is loaded. Decoder don't-care X values never reach ex_* while ex_valid = 0.
- Hazard term: haz = id_valid & ex_valid & (ex_opcode == LDR_OPCODE) & ex_wre & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
  - All 2^REG_AW registers are compared; there is no hardwired zero register.
- Per-cycle priority, highest first:
  1. flush_i: load a bubble and set FSM = RUN, counter = 0. stall_o = 0. bubble_count increments.
  2. ex_hold_i: every register holds, including FSM and counter. stall_o = 1. No bubble is counted.
  3. FSM = STALL: load a bubble and decrement the counter. When the counter reaches 0, go to RUN. stall_o = 1. bubble_count increments.
  4. FSM = RUN with haz: load a bubble and set counter = LOAD_STALL_CYCLES-1. Go to STALL if that value is non-zero, otherwise stay in RUN. stall_o = 1. bubble_count increments.
  5. Otherwise: load the id_* bundle, with ex_valid = id_valid. stall_o = 0. bubble_count increments only if id_valid = 0 and this was caused by a flush; plain empty slots are not counted.
- Latency: one cycle from id_* to ex_*.
- A load-use pair costs exactly LOAD_STALL_CYCLES bubbles. During those cycles the dependent instruction is held upstream by stall_o and is re-presented unchanged.
- Once FSM = STALL, the hazard is not re-evaluated; only the counter governs release.
- bubble_count saturates at 16'hFFFF.
- Reset mid-stall: immediate return to RUN with the bundle cleared. The upstream held instruction is then re-evaluated against the empty EX stage.
- Flush and hazard in the same cycle: flush wins and no stall is asserted.
- Hold and hazard in the same cycle: hold wins. The hazard is re-evaluated on the first cycle without hold.

Test Plan:
1. Reset with rst_n=0 mid-stream, then release.
   - Required: all ex_*=0, stall_o=0, bubble_count=0 before any clock edge.
2. add r3,r1,r2 (id_opcode=0001, id_rd1=5, id_rd2=7, wre=1) followed by sub.
   - Required: ex_opcode=0001, ex_rd1=5, ex_rd2=7 and ex_valid=1 one cycle later. No stall_o.
3. ldr r4 then add r5,r4,r1 (id_rs1=4, uses_rs1=1), LOAD_STALL_CYCLES=1.
   - Required: stall_o=1 for exactly 1 cycle, then one bubble with ex_wre=0. The add enters EX on the following cycle; bubble_count=1.
4. Same sequence with LOAD_STALL_CYCLES=3.
   - Required: stall_o high 3 consecutive cycles, 3 bubbles, bubble_count=3. The add then issues.
5. flush_i=1 in the second cycle of a 3-cycle stall.
   - Required: FSM returns to RUN, stall_o=0 that cycle, ex_valid=0. bubble_count advances by 1 for the flush.
6. ex_hold_i=1 for 2 cycles with an add in EX and a hazard pending.
   - Required: ex_* unchanged, stall_o=1 both cycles, no bubble counted. The hazard stall starts after hold drops.
